// File: rtl/stream_demux_1to2_if.sv
// Handshake bundle for the 1-to-2 stream demux: one input stream, two output streams, debug counters.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

interface stream_demux_1to2_if #(
    parameter int unsigned DATA_W = `DATA_BITS,
    parameter int unsigned CNT_W  = 8
);
    logic [DATA_W-1:0] Data_in;
    logic              in_valid;
    logic              sel;
    logic              in_ready;
    logic [DATA_W-1:0] Data_out1;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] Data_out2;
    logic              out2_valid;
    logic              out2_ready;
    logic [CNT_W-1:0]  cnt1;
    logic [CNT_W-1:0]  cnt2;

    modport master (
        output Data_in, in_valid, sel, out1_ready, out2_ready,
        input  in_ready, Data_out1, out1_valid, Data_out2, out2_valid, cnt1, cnt2
    );

    modport slave (
        input  Data_in, in_valid, sel, out1_ready, out2_ready,
        output in_ready, Data_out1, out1_valid, Data_out2, out2_valid, cnt1, cnt2
    );
endinterface

// File: rtl/stream_demux_1to2.sv
// Registered 1-to-2 stream demux: each accepted word is steered by sel into one of two
// independent FIFOs, each with its own valid/ready output and a wrapping delivery counter.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif

module stream_demux_1to2 #(
    parameter int unsigned DATA_W = `DATA_BITS,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    stream_demux_1to2_if.slave   bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [1:0] full;
    logic [1:0] push;
    logic [1:0] pop;
    logic [1:0] out_ready;
    logic       accept;

    // in_ready looks only at the selected FIFO's full flag: no in_valid or outN_ready path
    assign bus.in_ready = bus.sel ? !full[1] : !full[0];
    assign accept       = bus.in_valid & bus.in_ready;
    assign push[0]      = accept & !bus.sel;
    assign push[1]      = accept &  bus.sel;
    assign out_ready    = {bus.out2_ready, bus.out1_ready};

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  rd_ptr;
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr_n;
        logic [PTR_W-1:0]  wr_ptr_n;
        logic [OCC_W-1:0]  occ;
        logic [OCC_W-1:0]  occ_n;
        logic [DATA_W-1:0] head_q;
        logic [DATA_W-1:0] head_n;
        logic              valid_q;
        logic [CNT_W-1:0]  cnt_q;

        assign full[p] = (occ == OCC_W'(DEPTH));
        assign pop[p]  = valid_q & out_ready[p];

        // Next head: a word pushed into a slot that becomes the head is forwarded from Data_in
        always_comb begin
            rd_ptr_n = rd_ptr;
            wr_ptr_n = wr_ptr;
            head_n   = head_q;
            occ_n    = occ + OCC_W'(push[p]) - OCC_W'(pop[p]);
            if (pop[p]) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            if (push[p]) begin
                wr_ptr_n = wr_ptr + PTR_W'(1);
            end
            if (occ_n != '0) begin
                if (push[p] && (rd_ptr_n == wr_ptr)) begin
                    head_n = bus.Data_in;
                end else begin
                    head_n = mem[rd_ptr_n];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                occ     <= '0;
                head_q  <= '0;
                valid_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                rd_ptr  <= rd_ptr_n;
                wr_ptr  <= wr_ptr_n;
                occ     <= occ_n;
                head_q  <= head_n;
                valid_q <= (occ_n != '0);
                if (pop[p]) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end

        // Storage needs no reset: occupancy alone decides what is visible
        always_ff @(posedge clk) begin
            if (push[p]) begin
                mem[wr_ptr] <= bus.Data_in;
            end
        end
    end

    assign bus.Data_out1  = g_fifo[0].head_q;
    assign bus.out1_valid = g_fifo[0].valid_q;
    assign bus.cnt1       = g_fifo[0].cnt_q;
    assign bus.Data_out2  = g_fifo[1].head_q;
    assign bus.out2_valid = g_fifo[1].valid_q;
    assign bus.cnt2       = g_fifo[1].cnt_q;

endmodule
